uart_cmd_responder: RTL

//  Command responder on the parallel side of the UART top. Consumes received bytes
//  (RX_OUT_P/RX_OUT_V), decodes write/read command frames against an internal register

---
 rtl/uart_cmd_responder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder
//   Command responder on the parallel side of a UART. It decodes the received
//   byte stream into write frames {WR_CMD, addr, data} and read frames
//   {RD_CMD, addr} against an internal register file. Read data goes back out
//   through the transmitter's parallel input.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   asynchronous reset, active low
//   RX_OUT_P  in   received byte
//   RX_OUT_V  in   received-byte strobe, one-cycle pulse per byte
//   TX_OUT_B  in   transmitter busy
//   TX_IN_P   out  byte to transmit; held until the next send
//   TX_IN_V   out  transmit request, one-cycle pulse
//   WR_DONE   out  one-cycle pulse, cycle after a register write commits
//   DROP      out  one-cycle pulse, cycle after a received byte is discarded
module uart_cmd_responder #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = 8'hBB
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_OUT_P,
  input  logic                  RX_OUT_V,
  input  logic                  TX_OUT_B,
  output logic [DATA_WIDTH-1:0] TX_IN_P,
  output logic                  TX_IN_V,
  output logic                  WR_DONE,
  output logic                  DROP
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_SEND, RD_WAIT
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   tx_p_q, tx_p_d;
  logic                    tx_v_q, tx_v_d;
  logic                    wr_done_q, wr_done_d;
  logic                    drop_q, drop_d;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // Next-state / output decode. Opcode values are only meaningful in IDLE;
  // in the address and data states every byte is payload.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tx_p_d    = tx_p_q;
    tx_v_d    = 1'b0;
    wr_done_d = 1'b0;
    drop_d    = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (RX_OUT_V) begin
          if (RX_OUT_P == WR_CMD)      state_d = WR_ADDR;
          else if (RX_OUT_P == RD_CMD) state_d = RD_ADDR;
          else                         drop_d  = 1'b1;
        end
      end
      WR_ADDR: begin
        if (RX_OUT_V) begin
          addr_d  = RX_OUT_P[ADDR_WIDTH-1:0];  // upper address bits wrap
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_OUT_V) begin
          wr_en     = 1'b1;
          wr_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_OUT_V) begin
          addr_d  = RX_OUT_P[ADDR_WIDTH-1:0];
          state_d = RD_SEND;
        end
      end
      RD_SEND: begin
        // Incoming bytes are discarded while a response is pending; the send
        // itself proceeds regardless of RX activity.
        drop_d = RX_OUT_V;
        if (!TX_OUT_B) begin
          tx_v_d  = 1'b1;
          tx_p_d  = mem_q[addr_q];
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Stay here until the transmitter reports busy, so a second request
        // can never be issued before the first one was taken.
        drop_d = RX_OUT_V;
        if (TX_OUT_B) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      tx_p_q    <= '0;
      tx_v_q    <= 1'b0;
      wr_done_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tx_p_q    <= tx_p_d;
      tx_v_q    <= tx_v_d;
      wr_done_q <= wr_done_d;
      drop_q    <= drop_d;
    end
  end

  // Register file; cleared by reset so an abandoned session leaves no state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[addr_q] <= RX_OUT_P;
    end
  end

  assign TX_IN_P = tx_p_q;
  assign TX_IN_V = tx_v_q;
  assign WR_DONE = wr_done_q;
  assign DROP    = drop_q;

endmodule
